// File: rtl/ex_mem_register.sv
// EX/MEM pipeline boundary behind a registered ALU: realigns EX sideband, latches EX/MEM, and turns
// qualified overflow into a precise exception. Define OVF_COUNTER_EN to add the saturating ovfCount output.
module ex_mem_register #(
  parameter int         PC_W       = 32,
  parameter int         REG_ADDR_W = 5,
  parameter logic [4:0] OVF_CAUSE  = 5'd12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exValid,
  input  logic                  exRegWrite,
  input  logic                  exMemRead,
  input  logic                  exMemWrite,
  input  logic                  exOvfCheck,
  input  logic [REG_ADDR_W-1:0] exWriteReg,
  input  logic [31:0]           exStoreData,
  input  logic [PC_W-1:0]       exPC,
  input  logic [31:0]           ALUResult,
  input  logic                  overFlow,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  excAck,
  output logic                  memValid,
  output logic                  memRegWrite,
  output logic                  memMemRead,
  output logic                  memMemWrite,
  output logic [REG_ADDR_W-1:0] memWriteReg,
  output logic [31:0]           memALUResult,
  output logic [31:0]           memStoreData,
  output logic                  excReq,
  output logic [PC_W-1:0]       excEPC,
  output logic [4:0]            excCause,
  output logic                  exBlock
`ifdef OVF_COUNTER_EN
  ,
  output logic [15:0]           ovfCount
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ovf_check;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [31:0]           store_data;
    logic [PC_W-1:0]       pc;
  } slot_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [31:0]           alu_result;
    logic [31:0]           store_data;
  } mem_t;

  slot_t           ex_s;
  slot_t           a_q, a_d;
  mem_t            mem_q, mem_d;
  state_e          state_q, state_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [4:0]      cause_q, cause_d;

  logic pend_s;
  logic ovf_s;
  logic commit_s;
  logic take_s;

  assign ex_s = {exValid, exRegWrite, exMemRead, exMemWrite, exOvfCheck,
                 exWriteReg, exStoreData, exPC};

  // The ALU flag is stale for non add/sub ops, so only trust it for trapping instructions in slot A.
  assign pend_s   = (state_q == PEND);
  assign ovf_s    = a_q.valid & a_q.ovf_check & overFlow;
  assign commit_s = a_q.valid & ~pend_s & ~ovf_s;
  assign take_s   = ovf_s & ~pend_s & ~flush & ~stall;

  // Alignment slot: holds EX sideband for one cycle so it lines up with the registered ALU output.
  always_comb begin
    a_d = a_q;
    if (flush) begin
      a_d = '0;
    end else if (!stall) begin
      a_d = ex_s;
    end else begin
      a_d = a_q;
    end
  end

  // EX/MEM register: squashes write enables on a faulting instruction and kills everything while pending.
  always_comb begin
    mem_d = mem_q;
    if (flush) begin
      mem_d = '0;
    end else if (!stall) begin
      mem_d.valid      = a_q.valid & ~pend_s;
      mem_d.reg_write  = commit_s & a_q.reg_write;
      mem_d.mem_read   = commit_s & a_q.mem_read;
      mem_d.mem_write  = commit_s & a_q.mem_write;
      mem_d.write_reg  = a_q.write_reg;
      mem_d.alu_result = ALUResult;
      mem_d.store_data = a_q.store_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Exception FSM: only an acknowledge leaves PEND; flush does not cancel it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_s) begin
          state_d = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (excAck) begin
          state_d = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // EPC/cause capture on the edge the faulting instruction enters MEM; frozen otherwise.
  always_comb begin
    epc_d   = epc_q;
    cause_d = cause_q;
    if (take_s) begin
      epc_d   = a_q.pc;
      cause_d = OVF_CAUSE;
    end else begin
      epc_d   = epc_q;
      cause_d = cause_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      mem_q   <= '0;
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= 5'd0;
    end else begin
      a_q     <= a_d;
      mem_q   <= mem_d;
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

`ifdef OVF_COUNTER_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of taken overflow exceptions.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (take_s && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= 16'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovfCount = ovf_cnt_q;
`endif

  assign memValid     = mem_q.valid;
  assign memRegWrite  = mem_q.reg_write;
  assign memMemRead   = mem_q.mem_read;
  assign memMemWrite  = mem_q.mem_write;
  assign memWriteReg  = mem_q.write_reg;
  assign memALUResult = mem_q.alu_result;
  assign memStoreData = mem_q.store_data;
  assign excReq       = pend_s;
  assign exBlock      = pend_s;
  assign excEPC       = epc_q;
  assign excCause     = cause_q;

endmodule

// File: doc/ex_mem_register.md
Name: ex_mem_register

Overview:
- EX/MEM pipeline boundary directly downstream of the registered 32-bit ALU.
- The ALU registers its result and overflow on the clock edge, so ALUResult/overFlow arrive one cycle after the EX-stage control that produced them.
- This block realigns the EX control sideband to the ALU output, latches the EX/MEM register, and supports stall and flush.
- Converts a qualified arithmetic overflow into a precise exception: squashes the faulting write, captures EPC/cause, and holds a request until the coprocessor acknowledges.

Parameters:
- PC_W, 32, width of program counter carried with each instruction
- REG_ADDR_W, 5, destination register index width
- OVF_CAUSE, 5'd12, cause code reported for arithmetic overflow

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- exValid  in  1  EX stage holds a real instruction this cycle
- exRegWrite  in  1  instruction writes register file
- exMemRead  in  1  load
- exMemWrite  in  1  store
- exOvfCheck  in  1  instruction is trapping add/sub (add, addi, sub)
- exWriteReg  in  REG_ADDR_W  destination register
- exStoreData  in  32  rt value for stores
- exPC  in  PC_W  instruction PC
- ALUResult  in  32  ALU output (valid one cycle after ex* sideband)
- overFlow  in  1  ALU overflow flag (same timing as ALUResult)
- stall  in  1  hold EX/MEM contents (MEM stage busy)
- flush  in  1  kill instruction in alignment slot and EX/MEM
- excAck  in  1  exception handler has taken EPC/cause
- memValid  out  1  EX/MEM holds a real instruction
- memRegWrite  out  1
- memMemRead  out  1
- memMemWrite  out  1
- memWriteReg  out  REG_ADDR_W
- memALUResult  out  32
- memStoreData  out  32
- excReq  out  1  exception pending
- excEPC  out  PC_W  PC of faulting instruction
- excCause  out  5  cause code
- exBlock  out  1  upstream must not issue new instructions (exception in flight)

Behaviour:
- Reset (async, rst=1): all outputs 0, alignment slot invalid, FSM IDLE.
- Alignment slot: on each rising edge with stall=0, ex* sideband copied into slot A. With stall=1, A holds; upstream also stalls the ALU.
- EX/MEM register: on a rising edge with stall=0, loads from A plus ALUResult/overFlow. Total latency from ex* inputs to mem* outputs: 2 cycles; ALUResult to memALUResult: 1 cycle.
- Overflow qualifier: ovf = A.valid & A.ovfCheck & overFlow. overFlow is ignored for non-add/sub operations, because the ALU leaves the flag stale for them.
- On ovf in IDLE, the EX/MEM load occurs with memValid=1 but memRegWrite=memMemWrite=memMemRead=0 (result squashed).
  - Same edge: excEPC<=A.pc, excCause<=OVF_CAUSE, FSM->PEND.
- FSM states:
  - IDLE: normal flow. excReq=0, exBlock=0.
  - PEND: excReq=1, exBlock=1. Every instruction entering EX/MEM is loaded squashed (memValid=0). excEPC/excCause frozen; a second ovf is ignored. excAck=1 -> IDLE on the next edge.
- excAck while in IDLE: ignored.
- flush=1 (priority over stall): next edge clears A.valid and memValid, plus all write enables. A flush does not cancel PEND; only excAck leaves PEND.
- stall=1 with ovf: the exception is not taken until the edge on which EX/MEM actually loads (stall=0). EPC is therefore precise to the instruction entering MEM.
- Simultaneous flush and ovf: flush wins, no exception is raised (the faulting instruction was killed).
- rst mid-PEND: returns to IDLE, all exception outputs 0.

Optional Feature:
- Macro OVF_COUNTER_EN.
- Defined: adds output ovfCount[15:0], cleared by rst. Increments on each taken overflow exception (IDLE->PEND edge) and saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Normal flow: add with exRegWrite=1, exWriteReg=8, exPC=0x40, data 5+7. Next cycle ALUResult=12, overFlow=0.
  -> Two cycles after issue: memValid=1, memRegWrite=1, memWriteReg=8, memALUResult=12; excReq=0.
- Overflow: add 0x7FFFFFFF+1 with exOvfCheck=1, exPC=0x100, exRegWrite=1.
  -> memRegWrite=0, excReq=1, excEPC=0x100, excCause=12, exBlock=1.
  -> Following instructions memValid=0. excAck pulse -> excReq=0 next cycle.
- Stale flag: and instruction (exOvfCheck=0) while overFlow=1 from a prior add.
  -> No exception, memRegWrite=1, result passes through.
- Stall: stall=1 for 3 cycles with valid load in A.
  -> mem* outputs constant for 3 cycles; instruction appears on first stall=0 edge. Overflow during stall raises excReq only on that edge.
- Flush vs overflow: flush=1 coincident with ovf.
  -> memValid=0, excReq stays 0. Separately, flush while PEND keeps excReq=1.
- Reset mid-exception: assert rst asynchronously (between edges) while PEND.
  -> excReq, excEPC, memValid drop to 0 immediately. With OVF_COUNTER_EN, ovfCount=0.
